// File: rtl/bus_slave_rsp_mux_pkg.sv
// Shared types and constants for the bus slave response multiplexer.
// FSM encodings, default watchdog depth and active-low polarity constants.
package bus_slave_rsp_mux_pkg;

   localparam logic ENABLE_  = 1'b1;
   localparam logic DISABLE_ = 1'b0;
   localparam logic ACT_LO   = 1'b0;
   localparam logic INACT_LO = 1'b1;

   localparam int TIMEOUT_CYC_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_slave_rsp_mux_if.sv
// Master-side request/response bus and per-slave select/ready/data bundle.
// The mux itself uses the slave modport; the driver of requests uses master.
interface bus_slave_rsp_mux_if #(
   parameter int NUM_SLAVES = 8,
   parameter int DATA_W     = 32
);
   logic                         m_as_;
   logic [NUM_SLAVES-1:0]        s_cs_;
   logic [NUM_SLAVES*DATA_W-1:0] s_rd_data;
   logic [NUM_SLAVES-1:0]        s_rdy_;
   logic [DATA_W-1:0]            m_rd_data;
   logic                         m_rdy_;
   logic                         m_err;
   logic                         busy;

   modport master (
      output m_as_, s_cs_, s_rd_data, s_rdy_,
      input  m_rd_data, m_rdy_, m_err, busy
   );

   modport slave (
      input  m_as_, s_cs_, s_rd_data, s_rdy_,
      output m_rd_data, m_rdy_, m_err, busy
   );

endinterface

// File: rtl/bus_slave_rsp_mux_prio_enc.sv
// Lowest-index priority encoder over an active-low chip-select vector.
module bus_cs_prio_enc
   import bus_slave_rsp_mux_pkg::*;
#(
   parameter int NUM_SLAVES = 8,
   parameter int IDX_W      = idx_width(NUM_SLAVES)
) (
   input  logic [NUM_SLAVES-1:0] s_cs_,
   output logic [IDX_W-1:0]      index,
   output logic                  valid
);

   logic [IDX_W-1:0] w_idx;
   logic             w_vld;

   // Scan from the top so the lowest asserted select is the last one written.
   always_comb begin
      w_idx = '0;
      w_vld = 1'b0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (s_cs_[i] == ACT_LO) begin
            w_idx = IDX_W'(i);
            w_vld = 1'b1;
         end
      end
   end

   assign index = w_idx;
   assign valid = w_vld;

endmodule

// File: rtl/bus_slave_rsp_mux.sv
// Routes one selected slave's read response back to the bus master.
// Define BUS_SLAVE_TIMEOUT_EN to compile in the WAIT-state watchdog.
module bus_slave_rsp_mux
   import bus_slave_rsp_mux_pkg::*;
#(
   parameter int NUM_SLAVES  = 8,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                  clk,
   input  logic                  reset_,
   bus_slave_rsp_mux_if.slave    bus
);

   localparam int IDX_W = idx_width(NUM_SLAVES);

   if (NUM_SLAVES < 2 || NUM_SLAVES > 16) begin : g_bad_num_slaves
      $error("NUM_SLAVES must be in 2..16");
   end
   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be in 2..256");
   end

   state_t              r_state;
   logic [IDX_W-1:0]    r_sel;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_rdy_;
   logic                r_err;

   logic [IDX_W-1:0]    w_cs_idx;
   logic                w_cs_vld;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_sel_rdy_;

`ifdef BUS_SLAVE_TIMEOUT_EN
   localparam int               CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0]            r_cnt;
`endif

   bus_cs_prio_enc #(
      .NUM_SLAVES (NUM_SLAVES),
      .IDX_W      (IDX_W)
   ) u_prio_enc (
      .s_cs_ (bus.s_cs_),
      .index (w_cs_idx),
      .valid (w_cs_vld)
   );

   assign w_sel_data = bus.s_rd_data[r_sel*DATA_W +: DATA_W];
   assign w_sel_rdy_ = bus.s_rdy_[r_sel];

   // Response outputs default to idle every cycle so they only pulse in RESP.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_rd_data <= '0;
         r_rdy_    <= INACT_LO;
         r_err     <= DISABLE_;
`ifdef BUS_SLAVE_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_rd_data <= '0;
         r_rdy_    <= INACT_LO;
         r_err     <= DISABLE_;
         case (r_state)
            ST_IDLE: begin
               if (bus.m_as_ == ACT_LO) begin
                  if (w_cs_vld) begin
                     r_sel   <= w_cs_idx;
                     r_state <= ST_WAIT;
`ifdef BUS_SLAVE_TIMEOUT_EN
                     r_cnt   <= '0;
`endif
                  end else begin
                     r_rdy_  <= ACT_LO;
                     r_err   <= ENABLE_;
                     r_state <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (w_sel_rdy_ == ACT_LO) begin
                  r_rd_data <= w_sel_data;
                  r_rdy_    <= ACT_LO;
                  r_state   <= ST_RESP;
               end
`ifdef BUS_SLAVE_TIMEOUT_EN
               else if (r_cnt == CNT_MAX) begin
                  r_rdy_  <= ACT_LO;
                  r_err   <= ENABLE_;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.m_rd_data = r_rd_data;
   assign bus.m_rdy_    = r_rdy_;
   assign bus.m_err     = r_err;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: doc/bus_slave_rsp_mux.md
BUS_SLAVE_RSP_MUX -- requirements
Module: bus_slave_rsp_mux

Interface
REQ-001 Parameter NUM_SLAVES, default 8, number of slave ports (legal 2..16).
REQ-002 Parameter DATA_W, default 32, read data width.
REQ-003 Parameter TIMEOUT_CYC, default 16, maximum WAIT cycles before a bus error (legal 2..256).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, rising edge.
REQ-006 reset_  in  1  asynchronous active-low reset.
REQ-007 m_as_  in  1  master address strobe, active-low, one-cycle request pulse.
REQ-008 s_cs_  in  NUM_SLAVES  per-slave chip select, active-low.
REQ-009 s_rd_data  in  NUM_SLAVES*DATA_W  packed slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
REQ-010 s_rdy_  in  NUM_SLAVES  per-slave ready, active-low.
REQ-011 m_rd_data  out  DATA_W  registered read data to master.
REQ-012 m_rdy_  out  1  registered response strobe, active-low, one cycle.
REQ-013 m_err  out  1  registered bus error, high, qualified by m_rdy_ low.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE, when m_as_ is low and at least one s_cs_ bit is low, the block SHALL latch the lowest-index selected slave and enter WAIT.
REQ-017 In IDLE, when m_as_ is low and no s_cs_ bit is low (unmapped), the block SHALL enter RESP with m_err=1 and m_rd_data=0.
REQ-018 In WAIT, when the latched slave's s_rdy_ is sampled low, the block SHALL register that slave's s_rd_data and enter RESP with m_err=0.
REQ-019 In RESP, m_rdy_ SHALL be low for exactly one cycle; the next state SHALL be IDLE.
REQ-020 Minimum latency: m_as_ sampled at edge k, slave ready at edge k+1, m_rdy_ low from edge k+1 until k+2; unmapped: m_rdy_ low from edge k until k+1.
REQ-021 m_as_ SHALL be ignored outside IDLE; no request queuing.
REQ-022 s_rdy_ of non-latched slaves and s_cs_ changes after acceptance SHALL be ignored.
REQ-023 Outside RESP, m_rd_data SHALL be 0, m_rdy_ high and m_err 0.
REQ-024 Multiple simultaneous s_cs_ low SHALL resolve to the lowest index without error.

Reset
REQ-025 Asserting reset_ low SHALL immediately force IDLE, m_rd_data=0, m_rdy_=1, m_err=0, busy=0 and clear the timeout counter, including mid-WAIT or mid-RESP.
REQ-026 The first request SHALL be accepted on the first rising edge after reset_ deasserts.

Configuration
REQ-027 Macro BUS_SLAVE_TIMEOUT_EN SHALL be defined to compile in the watchdog.
REQ-028 With BUS_SLAVE_TIMEOUT_EN: the counter (width clog2(TIMEOUT_CYC)) SHALL clear on entering WAIT and increment on each WAIT cycle without ready; on a WAIT cycle with count == TIMEOUT_CYC-1 and no ready, the block SHALL enter RESP with m_err=1 and m_rd_data=0; ready on that same cycle SHALL win (normal response).
REQ-029 Without BUS_SLAVE_TIMEOUT_EN: no counter logic exists and WAIT SHALL persist until ready or reset.

Structure
REQ-030 FSM state encodings and the TIMEOUT_CYC default SHALL live in the block header bus_slave_rsp_mux.h; ENABLE_/DISABLE_ and polarity constants SHALL come from the global config header.
REQ-031 The lowest-index active-low select SHALL be one sub-module, bus_cs_prio_enc (inputs s_cs_, outputs index and valid).

Verification
REQ-032 Scenario: s_cs_[3] low with m_as_ low, s_rdy_[3] low next cycle with data 32'hDEAD_BEEF -> m_rdy_ low one cycle, m_rd_data=32'hDEAD_BEEF, m_err=0, two cycles after request.
REQ-033 Scenario: m_as_ low with all s_cs_ high -> m_rdy_ low the next cycle with m_err=1, m_rd_data=0.
REQ-034 Scenario: s_cs_[1] and s_cs_[5] both low, s_rdy_[5] low and s_rdy_[1] low three cycles later with 32'h0000_1111 -> response only after s_rdy_[1], data 32'h0000_1111.
REQ-035 Scenario (BUS_SLAVE_TIMEOUT_EN, TIMEOUT_CYC=16): slave 2 selected, s_rdy_ held high -> m_rdy_ low after exactly 16 WAIT cycles with m_err=1; ready on the 16th cycle gives m_err=0.
REQ-036 Scenario: reset_ pulsed low during WAIT -> outputs return to reset values asynchronously, busy=0, and a new request to slave 0 then completes normally.
REQ-037 Scenario: m_as_ pulsed low during WAIT and during RESP -> no extra response; exactly one m_rdy_ pulse per accepted request.
